sh7604_ibus_initiator: RTL
==========================

# sh7604_ibus_initiator

Bus-master side of the SH7604 on-chip peripheral bus (IBUS). The block accepts one CPU-side byte, word or longword access at a time and drives a single IBUS transaction to the internal register responders (WDT, FRT, SCI, DIVU, ...). It handles big-endian lane steering, write-data replication and BUSY wait states. Longword accesses to the 16-bit register window are split into two word cycles. It sits between the CPU's internal data bus and the IBUS fan-out/read-mux.

## Interface
Parameters:
- TIMEOUT, 8'd255, maximum number of IBUS_BUSY-stalled CE_R ticks before a cycle is aborted.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- CE_R / CE_F  in  1  rising/falling phase enables; all state advances on CE_R only
- EN  in  1  block enable; when low, the FSM holds its state
- RES_N  in  1  synchronous chip reset; returns the block to reset values on any CLK edge
- CPU_A  in  32  access address
- CPU_DI  in  32  write data, right-justified
- CPU_SZ  in  2  access size: 0 = byte, 1 = word, 2 = long, 3 = reserved (treated as long)
- CPU_WE / CPU_REQ  in  1  write strobe; access request (level, held until CPU_ACK)
- CPU_DO  out  32  read data, right-justified and zero-extended
- CPU_ACK  out  1  one-CE_R-tick completion pulse
- CPU_BERR  out  1  one-tick pulse with CPU_ACK: no responder or timeout
- CPU_AERR  out  1  one-tick pulse with CPU_ACK: misaligned access
- IBUS_A  out  32  responder address
- IBUS_DO  out  32  write data, lane-replicated
- IBUS_DI  in  32  read data from the responder mux
- IBUS_BA  out  4  byte-lane enables; bit 3 = lane [31:24]
- IBUS_WE / IBUS_REQ  out  1  IBUS write strobe and request
- IBUS_BUSY / IBUS_ACT  in  1  responder wait state; responder address hit

## Operation
- FSM states: IDLE, CYC1, CYC2, DONE.
- IDLE:
  - Accepts a request when CPU_REQ is high and CPU_ACK is low.
  - Misaligned access (word with A[0] set, long with A[1:0] nonzero): goes directly to DONE with AERR; no IBUS cycle is issued.
  - Aligned access: goes to CYC1.
- Lane mapping (big-endian):
  - byte k = A[1:0] uses BA = 4'b1000>>k and data DI[31-8k -: 8];
  - word uses BA = 1100 when A[1]=0, 0011 when A[1]=1;
  - long uses BA = 1111.
- Write data replication: byte data is replicated ×4; word data is replicated ×2; long data passes through.
- Split: a long access in the range FFFFFE00–FFFFFEFF becomes a word cycle at A (CYC1) followed by a word cycle at A+2 (CYC2). The result is CPU_DO = {first word, second word}.
- CYC completion: a cycle completes on the first CE_R tick with IBUS_BUSY=0.
  - IBUS_ACT=1: IBUS_DI is sampled and lane-extracted.
  - IBUS_ACT=0: read data is forced to 0 and BERR is latched.
- BUSY counter:
  - Width is 8 bits; it is cleared on entry to each CYC state.
  - It increments on each stalled tick.
  - When it reaches TIMEOUT, the cycle is aborted with BERR.
  - On abort, read data is 0 and CYC2 is skipped.
- DONE: CPU_ACK, CPU_DO and the error flags are held valid for exactly one CE_R tick, then the FSM returns to IDLE. CPU_DO keeps its value until the next DONE.
- A BERR in CYC1 of a split access skips CYC2.

## Timing
- Reset values (RST_N low or RES_N low): state IDLE; every output 0, including IBUS_A, IBUS_BA, IBUS_REQ and CPU_DO.
- The request is accepted on CE_R tick n. IBUS_REQ, IBUS_A, IBUS_BA, IBUS_WE and IBUS_DO are registered and valid from tick n.
  - The responder samples writes at CE_R tick n+1.
  - The responder registers read data on CE_F between ticks n and n+1.
- With zero wait states, the cycle completes at tick n+1 and CPU_ACK is high for tick n+2. A split access adds one tick.
- Each BUSY tick adds one tick of latency. IBUS outputs stay stable while BUSY is high.
- IBUS_REQ drops in DONE.
- RES_N asserted mid-cycle: the cycle is abandoned immediately; no CPU_ACK is issued.
- EN low: the FSM and counter freeze; outputs hold their values.

## Structure
- Shared SH7604_PKG holds:
  - the IBUS_SZ_t enum (BYTE, WORD, LONG);
  - the IBUS_STATE_t enum;
  - the IBUS_W16_BASE/IBUS_W16_END constants (FFFFFE00/FFFFFEFF);
  - lane helper functions (ba_gen, wdata_rep, rdata_ext).
- One combinational sub-module, sh7604_ibus_lane, performs BA generation, write replication and read extraction. It is reused per half of a split access.

## Test plan
- Byte write 8'h3C to FFFFFE81 with zero wait states -> IBUS_BA=0100, IBUS_DO=3C3C3C3C, IBUS_REQ high for one tick, CPU_ACK two ticks after acceptance.
- Word read at FFFFFE92, responder returns 0000ABCD -> BA=0011, CPU_DO=0000ABCD, BERR=0.
- Long read at FFFFFE10 (split), responder returns 1234 then 5678 -> two cycles at FFFFFE10 and FFFFFE12, CPU_DO=12345678, ACK three ticks after acceptance.
- Long read at FFFFFF00 with IBUS_BUSY held for 3 ticks -> single cycle, ACK at tick n+5, IBUS outputs stable during the stall.
- Read at FFFFFD00 with IBUS_ACT=0, then a BUSY-forever read with TIMEOUT=4 -> CPU_DO=0 and BERR pulse in both cases; the timeout aborts after 4 stalled ticks.
- Word access at FFFFFE81 -> AERR pulse, IBUS_REQ never asserted. Separately, RES_N pulsed during CYC1 -> all outputs 0, no ACK, next request serviced normally.

Source files
------------

// File: rtl/sh7604_pkg.sv
// sh7604_pkg
//   Shared types, constants and lane helpers for the SH7604 IBUS master.
//   Byte lanes are big-endian: lane 3 (BA bit 3) is data bits [31:24] and
//   holds the byte at address offset 0.
package sh7604_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    WORD = 2'd1,
    LONG = 2'd2
  } IBUS_SZ_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CYC1 = 2'd1,
    CYC2 = 2'd2,
    DONE = 2'd3
  } IBUS_STATE_t;

  // Responders in this window are only 16 bits wide.
  localparam logic [31:0] IBUS_W16_BASE = 32'hFFFF_FE00;
  localparam logic [31:0] IBUS_W16_END  = 32'hFFFF_FEFF;

  // The reserved size code 3 behaves as a longword.
  function automatic IBUS_SZ_t sz_decode(input logic [1:0] sz);
    case (sz)
      2'd0:    return BYTE;
      2'd1:    return WORD;
      default: return LONG;
    endcase
  endfunction

  function automatic logic misaligned(input IBUS_SZ_t sz, input logic [1:0] a);
    case (sz)
      WORD:    return a[0];
      LONG:    return |a;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ba_gen(input IBUS_SZ_t sz, input logic [1:0] a);
    case (sz)
      BYTE:    return 4'b1000 >> a;
      WORD:    return a[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input IBUS_SZ_t sz, input logic [31:0] d);
    case (sz)
      BYTE:    return {4{d[7:0]}};
      WORD:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] rdata_ext(input IBUS_SZ_t sz, input logic [1:0] a,
                                            input logic [31:0] d);
    case (sz)
      BYTE: begin
        case (a)
          2'd0:    return {24'h0, d[31:24]};
          2'd1:    return {24'h0, d[23:16]};
          2'd2:    return {24'h0, d[15:8]};
          default: return {24'h0, d[7:0]};
        endcase
      end
      WORD:    return a[1] ? {16'h0, d[15:0]} : {16'h0, d[31:16]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/sh7604_ibus_lane.sv
// sh7604_ibus_lane
//   Combinational lane steering for one IBUS cycle.
//   sz, addr : size and low address bits of the cycle on the bus
//   wdata    : right-justified write data  -> wrep : lane-replicated data
//   rdata    : raw responder data          -> rext : right-justified, zero-extended
//   ba       : byte-lane enables
module sh7604_ibus_lane
  import sh7604_pkg::*;
(
  input  IBUS_SZ_t    sz,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  ba,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  assign ba   = ba_gen(sz, addr);
  assign wrep = wdata_rep(sz, wdata);
  assign rext = rdata_ext(sz, addr, rdata);

endmodule

// File: rtl/sh7604_ibus_initiator.sv
// sh7604_ibus_initiator
//   Takes one CPU access at a time and runs it as one IBUS cycle, or as two
//   word cycles for a longword to the 16-bit register window.
//   Handshake: the CPU holds CPU_REQ (with CPU_A/CPU_DI/CPU_SZ/CPU_WE stable)
//   until it sees CPU_ACK; CPU_ACK and the error flags are valid for exactly
//   one CE_R tick. On the IBUS side IBUS_REQ stays high with stable address,
//   lanes and data until a CE_R tick with IBUS_BUSY low ends the cycle.
//   Ports: CLK/RST_N clock and async reset; CE_R/CE_F phase enables; EN
//   freeze; RES_N synchronous chip reset; CPU_* CPU side; IBUS_* responder
//   side; DBG_STATE current FSM state.
module sh7604_ibus_initiator
  import sh7604_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic        RES_N,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic [1:0]  CPU_SZ,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  output logic [31:0] CPU_DO,
  output logic        CPU_ACK,
  output logic        CPU_BERR,
  output logic        CPU_AERR,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT,
  output IBUS_STATE_t DBG_STATE
);

  IBUS_STATE_t state, state_nx;
  IBUS_SZ_t    cur_sz, req_sz;
  logic [31:0] a_reg, cur_wd, cpu_do_r;
  logic [15:0] lo_wd, hi_word;
  logic [7:0]  busy_cnt;
  logic        we_reg, split_reg, berr_r, aerr_r;
  logic        adv, accept, req_misal, req_split, timeout_hit;
  logic [3:0]  lane_ba;
  logic [31:0] lane_wrep, lane_rext, rd_val;
  logic        unused;

  // CE_F is only meaningful to responders; nothing here advances on it.
  assign unused = CE_F;

  assign adv       = CE_R & EN;
  assign req_sz    = sz_decode(CPU_SZ);
  assign req_misal = misaligned(req_sz, CPU_A[1:0]);
  assign req_split = (req_sz == LONG) && (CPU_A >= IBUS_W16_BASE) && (CPU_A <= IBUS_W16_END);
  assign accept    = (state == IDLE) && CPU_REQ && !CPU_ACK;
  // True on the stalled tick that would bring the count up to TIMEOUT.
  assign timeout_hit = ({1'b0, busy_cnt} + 9'd1) >= {1'b0, TIMEOUT};
  // A missing responder or a write yields no read data.
  assign rd_val    = (IBUS_ACT && !we_reg) ? lane_rext : 32'h0;

  // One lane unit serves whichever half of the access is on the bus.
  sh7604_ibus_lane u_lane (
    .sz    (cur_sz),
    .addr  (a_reg[1:0]),
    .wdata (cur_wd),
    .rdata (IBUS_DI),
    .ba    (lane_ba),
    .wrep  (lane_wrep),
    .rext  (lane_rext)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      state <= IDLE;
    else if (!RES_N) state <= IDLE;
    else if (adv)    state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = req_misal ? DONE : CYC1;
      CYC1: begin
        if (!IBUS_BUSY)       state_nx = (split_reg && IBUS_ACT) ? CYC2 : DONE;
        else if (timeout_hit) state_nx = DONE;
      end
      CYC2: if (!IBUS_BUSY || timeout_hit) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    CPU_ACK  = (state == DONE);
    CPU_BERR = (state == DONE) && berr_r;
    CPU_AERR = (state == DONE) && aerr_r;
    IBUS_REQ = (state == CYC1) || (state == CYC2);
    IBUS_WE  = IBUS_REQ && we_reg;
    IBUS_BA  = IBUS_REQ ? lane_ba : 4'h0;
  end

  assign CPU_DO    = cpu_do_r;
  assign IBUS_A    = a_reg;
  assign IBUS_DO   = lane_wrep;
  assign DBG_STATE = state;

  // Datapath: cycle parameters, busy counter, result capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_reg <= '0; cur_wd <= '0; lo_wd <= '0; hi_word <= '0; cur_sz <= BYTE;
      we_reg <= 1'b0; split_reg <= 1'b0; busy_cnt <= '0;
      berr_r <= 1'b0; aerr_r <= 1'b0; cpu_do_r <= '0;
    end else if (!RES_N) begin
      a_reg <= '0; cur_wd <= '0; lo_wd <= '0; hi_word <= '0; cur_sz <= BYTE;
      we_reg <= 1'b0; split_reg <= 1'b0; busy_cnt <= '0;
      berr_r <= 1'b0; aerr_r <= 1'b0; cpu_do_r <= '0;
    end else if (adv) begin
      case (state)
        IDLE: begin
          if (accept) begin
            aerr_r <= req_misal;
            berr_r <= 1'b0;
            if (req_misal) begin
              cpu_do_r <= '0;
            end else begin
              a_reg     <= CPU_A;
              we_reg    <= CPU_WE;
              split_reg <= req_split;
              cur_sz    <= req_split ? WORD : req_sz;
              // A split longword sends its high half first.
              cur_wd    <= req_split ? {16'h0, CPU_DI[31:16]} : CPU_DI;
              lo_wd     <= CPU_DI[15:0];
              busy_cnt  <= '0;
            end
          end
        end
        CYC1, CYC2: begin
          if (!IBUS_BUSY) begin
            if (state == CYC1 && split_reg && IBUS_ACT) begin
              hi_word  <= rd_val[15:0];
              a_reg    <= a_reg + 32'd2;
              cur_wd   <= {16'h0, lo_wd};
              busy_cnt <= '0;
            end else begin
              berr_r <= !IBUS_ACT;
              if (state == CYC2) cpu_do_r <= IBUS_ACT ? {hi_word, rd_val[15:0]} : 32'h0;
              else               cpu_do_r <= rd_val;
            end
          end else if (timeout_hit) begin
            berr_r   <= 1'b1;
            cpu_do_r <= '0;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
